// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage issuing loads/stores over req/gnt/rvalid and stalling upstream while busy.
module mem_access_stage #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int DMEM_ADDR_WIDTH    = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          in_load,
  input  logic                          in_store,
  input  logic [DATAPATH_WIDTH-1:0]     in_addr,
  input  logic [DATAPATH_WIDTH-1:0]     in_wdata,
  input  logic [DATAPATH_WIDTH-1:0]     accum_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
  output logic                          stall,
  output logic                          out_valid,
  output logic [DATAPATH_WIDTH-1:0]     mem_data_out,
  output logic [DATAPATH_WIDTH-1:0]     accum_out,
  output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
  output logic                          err_out,
  output logic                          dmem_req,
  output logic                          dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]    dmem_addr,
  output logic [DATAPATH_WIDTH-1:0]     dmem_wdata,
  input  logic                          dmem_gnt,
  input  logic                          dmem_rvalid,
  input  logic [DATAPATH_WIDTH-1:0]     dmem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  state_t                          r_state;
  logic                            r_store;
  logic [DMEM_ADDR_WIDTH-1:0]      r_addr;
  logic [DATAPATH_WIDTH-1:0]       r_wdata;
  logic [DATAPATH_WIDTH-1:0]       r_accum;
  logic [DATAPATH_WIDTH-1:0]       r_rdata;
  logic [REGFILE_ADDR_WIDTH-1:0]   r_wr;
  logic w_idle, w_resp, w_mem, w_fault, w_accept, w_pass;
  assign w_idle   = r_state == S_IDLE;
  assign w_resp   = r_state == S_RESP;
  assign w_mem    = in_valid & (in_load | in_store);
  // Faults are decided in IDLE alone, so they never touch the memory bus.
  assign w_fault  = w_mem & ((in_addr[2:0] != 3'd0) | (|in_addr[DATAPATH_WIDTH-1:DMEM_ADDR_WIDTH+3]) | (in_load & in_store));
  assign w_accept = w_idle & w_mem & ~w_fault;
  assign w_pass   = w_idle & in_valid & ~w_accept;
  always_comb begin
    stall        = w_accept | (r_state == S_REQ) | (r_state == S_WAIT);
    out_valid    = w_pass | w_resp;
    err_out      = w_idle & w_fault;
    accum_out    = w_pass ? accum_in : w_resp ? r_accum : '0;
    WR_addr_out  = (w_pass & ~w_mem) ? WR_addr_in : (w_resp & ~r_store) ? r_wr : '0;
    mem_data_out = (w_resp & ~r_store) ? r_rdata : '0;
    dmem_req     = r_state == S_REQ;
    dmem_we      = dmem_req & r_store;
    dmem_addr    = r_addr;
    dmem_wdata   = r_wdata;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_store <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_accum <= '0;
      r_rdata <= '0;
      r_wr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_state <= S_REQ;
          r_store <= in_store;
          r_addr  <= in_addr[DMEM_ADDR_WIDTH+2:3];
          r_wdata <= in_wdata;
          r_accum <= accum_in;
          r_wr    <= WR_addr_in;
        end
        S_REQ: if (dmem_gnt) begin
          if (r_store) r_state <= S_RESP;
          else if (dmem_rvalid) begin
            r_rdata <= dmem_rdata;
            r_state <= S_RESP;
          end else r_state <= S_WAIT;
        end
        S_WAIT: if (dmem_rvalid) begin
          r_rdata <= dmem_rdata;
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of pass-through, loads, stores, faults, back-to-back and reset abort.
module tb_mem_access_stage;
  logic        clk = 0, reset = 0;
  logic        in_valid = 0, in_load = 0, in_store = 0;
  logic [63:0] in_addr = 0, in_wdata = 0, accum_in = 0;
  logic [4:0]  WR_addr_in = 0;
  logic        stall, out_valid, err_out, dmem_req, dmem_we;
  logic [63:0] mem_data_out, accum_out, dmem_wdata;
  logic [4:0]  WR_addr_out;
  logic [9:0]  dmem_addr;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [63:0] dmem_rdata = 0;
  int n_tests = 0, n_fail = 0;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_addr(in_addr), .in_wdata(in_wdata), .accum_in(accum_in), .WR_addr_in(WR_addr_in),
    .stall(stall), .out_valid(out_valid), .mem_data_out(mem_data_out), .accum_out(accum_out),
    .WR_addr_out(WR_addr_out), .err_out(err_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] acc, input logic [4:0] wr);
    in_valid = v; in_load = ld; in_store = st; in_addr = a; in_wdata = wd; accum_in = acc; WR_addr_in = wr;
  endtask

  initial begin
    tick(); tick();
    check("rst_stall", 64'(stall), 0);
    check("rst_ov", 64'(out_valid), 0);
    check("rst_req", 64'(dmem_req), 0);
    reset = 1;
    tick();
    // pass-through
    set_op(1, 0, 0, 64'h0, 64'h0, 64'h1234, 5'd7);
    #1;
    check("pt_ov", 64'(out_valid), 1);
    check("pt_acc", accum_out, 64'h1234);
    check("pt_wr", 64'(WR_addr_out), 7);
    check("pt_stall", 64'(stall), 0);
    check("pt_req", 64'(dmem_req), 0);
    check("pt_md", mem_data_out, 0);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("idle_ov", 64'(out_valid), 0);
    check("idle_acc", accum_out, 0);
    tick();
    // load, zero wait
    set_op(1, 1, 0, 64'h40, 0, 64'h99, 5'd5);
    #1;
    check("ld_acc_stall", 64'(stall), 1);
    check("ld_acc_ov", 64'(out_valid), 0);
    tick();
    dmem_gnt = 1;
    #1;
    check("ld_req", 64'(dmem_req), 1);
    check("ld_we", 64'(dmem_we), 0);
    check("ld_addr", 64'(dmem_addr), 8);
    check("ld_req_stall", 64'(stall), 1);
    tick();
    dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 64'hDEADBEEF_CAFEF00D;
    #1;
    check("ld_wait_req", 64'(dmem_req), 0);
    check("ld_wait_stall", 64'(stall), 1);
    tick();
    dmem_rvalid = 0; dmem_rdata = 0;
    #1;
    check("ld_resp_ov", 64'(out_valid), 1);
    check("ld_resp_stall", 64'(stall), 0);
    check("ld_resp_md", mem_data_out, 64'hDEADBEEF_CAFEF00D);
    check("ld_resp_wr", 64'(WR_addr_out), 5);
    check("ld_resp_acc", accum_out, 64'h99);
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ld_after_ov", 64'(out_valid), 0);
    // store with gnt on the third REQ cycle
    set_op(1, 0, 1, 64'h18, 64'hAA, 64'h55, 5'd9);
    #1;
    check("st_acc_stall", 64'(stall), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      dmem_gnt = (i == 2);
      #1;
      check($sformatf("st_req%0d", i), 64'(dmem_req), 1);
      check($sformatf("st_we%0d", i), 64'(dmem_we), 1);
      check($sformatf("st_addr%0d", i), 64'(dmem_addr), 3);
      check($sformatf("st_wd%0d", i), dmem_wdata, 64'hAA);
      check($sformatf("st_stall%0d", i), 64'(stall), 1);
      tick();
    end
    dmem_gnt = 0;
    #1;
    check("st_resp_ov", 64'(out_valid), 1);
    check("st_resp_wr", 64'(WR_addr_out), 0);
    check("st_resp_md", mem_data_out, 0);
    check("st_resp_stall", 64'(stall), 0);
    check("st_resp_req", 64'(dmem_req), 0);
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    // faults
    set_op(1, 1, 0, 64'h41, 0, 0, 5'd3);
    #1;
    check("f_mis_err", 64'(err_out), 1);
    check("f_mis_ov", 64'(out_valid), 1);
    check("f_mis_stall", 64'(stall), 0);
    check("f_mis_wr", 64'(WR_addr_out), 0);
    tick();
    set_op(1, 0, 1, 64'h1 << 20, 0, 0, 5'd3);
    #1;
    check("f_rng_req", 64'(dmem_req), 0);
    check("f_rng_err", 64'(err_out), 1);
    check("f_rng_ov", 64'(out_valid), 1);
    check("f_rng_stall", 64'(stall), 0);
    tick();
    set_op(1, 1, 1, 64'h8, 0, 0, 5'd3);
    #1;
    check("f_both_req", 64'(dmem_req), 0);
    check("f_both_err", 64'(err_out), 1);
    check("f_both_ov", 64'(out_valid), 1);
    check("f_both_stall", 64'(stall), 0);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("f_after_req", 64'(dmem_req), 0);
    check("f_after_err", 64'(err_out), 0);
    tick();
    // back-to-back loads with rvalid coincident with gnt
    set_op(1, 1, 0, 64'h0, 0, 0, 5'd1);
    #1;
    check("bb1_acc_ov", 64'(out_valid), 0);
    tick();
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 64'h1111;
    #1;
    check("bb1_addr", 64'(dmem_addr), 0);
    check("bb1_req_ov", 64'(out_valid), 0);
    tick();
    dmem_gnt = 0; dmem_rvalid = 0;
    #1;
    check("bb1_resp_ov", 64'(out_valid), 1);
    check("bb1_resp_md", mem_data_out, 64'h1111);
    check("bb1_resp_wr", 64'(WR_addr_out), 1);
    tick();
    set_op(1, 1, 0, 64'h8, 0, 0, 5'd2);
    dmem_rvalid = 1; dmem_rdata = 64'hBAD;
    #1;
    check("bb2_acc_ov", 64'(out_valid), 0);
    check("bb2_acc_stall", 64'(stall), 1);
    tick();
    dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 64'h2222;
    #1;
    check("bb2_addr", 64'(dmem_addr), 1);
    check("bb2_req_ov", 64'(out_valid), 0);
    tick();
    dmem_gnt = 0; dmem_rvalid = 0;
    #1;
    check("bb2_resp_ov", 64'(out_valid), 1);
    check("bb2_resp_md", mem_data_out, 64'h2222);
    check("bb2_resp_wr", 64'(WR_addr_out), 2);
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    // reset while waiting for read data
    set_op(1, 1, 0, 64'h10, 0, 64'h77, 5'd4);
    tick();
    dmem_gnt = 1;
    tick();
    dmem_gnt = 0;
    #1;
    check("rw_wait_stall", 64'(stall), 1);
    reset = 0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rw_stall", 64'(stall), 0);
    check("rw_req", 64'(dmem_req), 0);
    check("rw_ov", 64'(out_valid), 0);
    check("rw_addr", 64'(dmem_addr), 0);
    tick();
    reset = 1;
    tick();
    dmem_rvalid = 1; dmem_rdata = 64'h3333;
    #1;
    check("rw_late_ov", 64'(out_valid), 0);
    tick();
    dmem_rvalid = 0;
    #1;
    check("rw_late_ov2", 64'(out_valid), 0);
    check("rw_late_md", mem_data_out, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
